// File: rtl/dsp_console.sv
// ----------------------------------------------------------------------------
// dsp_console
//   Bus initiator for the dsp text display. Converts a valid/ready byte stream
//   into dsp bus cycles. It keeps the cursor, interprets control codes, wraps
//   long lines, clears the screen and scrolls by copying cells one row up.
//
// Ports
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high
//   in_data    in   8   character or control byte
//   in_valid   in   1   in_data valid
//   in_ready   out  1   console accepts in_data this cycle (IDLE only)
//   dsp_en     out  1   bus request
//   dsp_wr     out  1   1 = write, 0 = read
//   dsp_addr   out  12  cell address {row[4:0], col[6:0]}
//   dsp_wdata  out  16  {attr, char}
//   dsp_rdata  in   16  read data, valid while wt=0
//   dsp_wt     in   1   wait; a cycle completes on an edge with en=1, wt=0
//
// Control bytes: CR -> column 0, LF -> next line at column 0 (scrolling on
// the last row), BS -> column-1 unless already at 0, FF -> clear screen and
// home the cursor. Printable 0x20..0x7E is written at the cursor. Anything
// else is dropped without a bus cycle.
// ----------------------------------------------------------------------------
module dsp_console #(
   parameter int         COLS = 80,
   parameter int         ROWS = 30,
   parameter logic [7:0] ATTR = 8'h07
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        dsp_en,
   output logic        dsp_wr,
   output logic [11:0] dsp_addr,
   output logic [15:0] dsp_wdata,
   input  logic [15:0] dsp_rdata,
   input  logic        dsp_wt
);

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      PUT,
      NEWLINE,
      SCROLL,
      CLR_ROW,
      CLR_ALL
   } state_t;

   localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);
   localparam logic [4:0]  PENULT_ROW = 5'(ROWS - 2);
   localparam logic [15:0] BLANK      = {ATTR, 8'h20};

   state_t     state;
   logic [7:0] char_q;
   logic [4:0] cur_row;
   logic [6:0] cur_col;
   logic [4:0] scan_row;    // row walked by SCROLL / CLR_ROW / CLR_ALL
   logic [6:0] scan_col;
   logic       scroll_wr;   // SCROLL phase: 0 = read below, 1 = write back
   logic       bus_done;

   assign bus_done = dsp_en & ~dsp_wt;

   // Every bus state follows the same pattern: with en low, present the
   // request; with en high, hold everything until the completing edge, then
   // drop en. That leaves one idle cycle between transfers.
   // NOTE: all state here is assigned with <= so every register samples the
   // pre-edge values; blocking assignments would create order-dependent logic.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= CLR_ALL;
         in_ready  <= 1'b0;
         dsp_en    <= 1'b0;
         dsp_wr    <= 1'b0;
         dsp_addr  <= '0;
         dsp_wdata <= '0;
         char_q    <= '0;
         cur_row   <= '0;
         cur_col   <= '0;
         scan_row  <= '0;
         scan_col  <= '0;
         scroll_wr <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  char_q   <= in_data;
                  in_ready <= 1'b0;
                  state    <= DECODE;
               end
            end

            DECODE: begin
               if (char_q inside {[8'h20:8'h7e]}) begin
                  // Request issued straight from DECODE so en rises one
                  // cycle after the accepting edge.
                  dsp_en    <= 1'b1;
                  dsp_wr    <= 1'b1;
                  dsp_addr  <= {cur_row, cur_col};
                  dsp_wdata <= {ATTR, char_q};
                  state     <= PUT;
               end else begin
                  case (char_q)
                     8'h0d: begin
                        cur_col  <= '0;
                        state    <= IDLE;
                        in_ready <= 1'b1;
                     end
                     8'h0a: state <= NEWLINE;
                     8'h08: begin
                        if (cur_col != '0) cur_col <= cur_col - 7'd1;
                        state    <= IDLE;
                        in_ready <= 1'b1;
                     end
                     8'h0c: begin
                        cur_row  <= '0;
                        cur_col  <= '0;
                        scan_row <= '0;
                        scan_col <= '0;
                        state    <= CLR_ALL;
                     end
                     default: begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                     end
                  endcase
               end
            end

            PUT: begin
               if (bus_done) begin
                  dsp_en <= 1'b0;
                  if (cur_col == LAST_COL) begin
                     state <= NEWLINE;   // col resets to 0 there
                  end else begin
                     cur_col  <= cur_col + 7'd1;
                     state    <= IDLE;
                     in_ready <= 1'b1;
                  end
               end
            end

            NEWLINE: begin
               cur_col <= '0;
               if (cur_row < LAST_ROW) begin
                  cur_row  <= cur_row + 5'd1;
                  state    <= IDLE;
                  in_ready <= 1'b1;
               end else begin
                  // Cursor stays on the last row; the screen moves instead.
                  // A one-row screen has nothing to copy, only the clear.
                  scan_row  <= '0;
                  scan_col  <= '0;
                  scroll_wr <= 1'b0;
                  state     <= (ROWS > 1) ? SCROLL : CLR_ROW;
               end
            end

            SCROLL: begin
               if (!dsp_en) begin
                  dsp_en   <= 1'b1;
                  dsp_wr   <= scroll_wr;
                  dsp_addr <= scroll_wr ? {scan_row, scan_col}
                                        : {scan_row + 5'd1, scan_col};
               end else if (!dsp_wt) begin
                  dsp_en <= 1'b0;
                  if (!scroll_wr) begin
                     dsp_wdata <= dsp_rdata;   // copied unchanged to the row above
                     scroll_wr <= 1'b1;
                  end else begin
                     scroll_wr <= 1'b0;
                     if (scan_col == LAST_COL) begin
                        scan_col <= '0;
                        if (scan_row == PENULT_ROW) begin
                           scan_row <= LAST_ROW;
                           state    <= CLR_ROW;
                        end else begin
                           scan_row <= scan_row + 5'd1;
                        end
                     end else begin
                        scan_col <= scan_col + 7'd1;
                     end
                  end
               end
            end

            CLR_ROW, CLR_ALL: begin
               if (!dsp_en) begin
                  dsp_en    <= 1'b1;
                  dsp_wr    <= 1'b1;
                  dsp_addr  <= {scan_row, scan_col};
                  dsp_wdata <= BLANK;
               end else if (!dsp_wt) begin
                  dsp_en <= 1'b0;
                  if (scan_col == LAST_COL) begin
                     scan_col <= '0;
                     if (state == CLR_ROW || scan_row == LAST_ROW) begin
                        scan_row <= '0;
                        state    <= IDLE;
                        in_ready <= 1'b1;
                     end else begin
                        scan_row <= scan_row + 5'd1;
                     end
                  end else begin
                     scan_col <= scan_col + 7'd1;
                  end
               end
            end

            default: begin
               dsp_en   <= 1'b0;
               in_ready <= 1'b0;
               scan_row <= '0;
               scan_col <= '0;
               state    <= CLR_ALL;
            end
         endcase
      end
   end

endmodule
